// File: rtl/skew_shift_array.sv
// Per-lane delay line that skews/deskews operand vectors at the systolic array edge.
// A drain sequencer flushes every lane with zeros after the last operand.
module skew_shift_array #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int BASE_DELAY = 1,
    parameter int DIRECTION  = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sync_reset_n,
    input  logic                        shift,
    input  logic                        in_valid,
    input  logic [LANES*DATA_WIDTH-1:0] data_i,
    input  logic                        drain_req,
    output logic [LANES*DATA_WIDTH-1:0] data_o,
    output logic [LANES-1:0]            valid_o,
    output logic                        empty_o,
    output logic                        busy_o,
    output logic                        drain_done_o
);

    localparam int MAX_DEPTH = BASE_DELAY + LANES - 1;
    localparam int CW        = $clog2(MAX_DEPTH + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            done_q;
    logic            done_n;
    logic            adv;
    logic            load_en;
    logic [LANES-1:0] lane_live;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (!sync_reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (drain_req) begin
                    state_n = DRAIN;
                    cnt_n   = CW'(MAX_DEPTH);
                end
            end
            DRAIN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        endcase
    end

    // While draining, every clock advances and the inputs are replaced by zeros.
    always_comb begin
        busy_o  = (state == DRAIN);
        load_en = (state == IDLE);
        adv     = (state == DRAIN) || shift;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int DEPTH = (DIRECTION == 0) ? BASE_DELAY + i
                                                : BASE_DELAY + LANES - 1 - i;

        logic [DEPTH-1:0][DATA_WIDTH-1:0] d_q;
        logic [DEPTH-1:0]                 v_q;
        logic [DATA_WIDTH-1:0]            d_in;
        logic                             v_in;

        assign d_in = load_en ? data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign v_in = load_en & in_valid;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                d_q <= '0;
                v_q <= '0;
            end else if (!sync_reset_n) begin
                d_q <= '0;
                v_q <= '0;
            end else if (adv) begin
                d_q[0] <= d_in;
                v_q[0] <= v_in;
                for (int k = 1; k < DEPTH; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = d_q[DEPTH-1];
        assign valid_o[i]                         = v_q[DEPTH-1];
        assign lane_live[i]                       = |v_q;
    end

    assign empty_o      = ~|lane_live;
    assign drain_done_o = done_q;

endmodule

// File: doc/skew_shift_array.md
Name: skew_shift_array

Overview:
- Multi-lane, per-lane-delayed shift register that skews or deskews operand vectors at the edges of the systolic matrix-multiplier array.
- Lane i is delayed by a lane-dependent number of shift steps.
- Each stage carries data plus a valid bit.
- A built-in drain sequencer flushes all lanes with zeros after the last operand, so the array completes its final partial products.

Parameters:
- DATA_WIDTH, 8, bit width of one lane element.
- LANES, 4, number of parallel lanes (>=1).
- BASE_DELAY, 1, stage count of the shortest lane (>=1).
- DIRECTION, 0, 0 = lane i depth BASE_DELAY+i (skew); 1 = lane i depth BASE_DELAY+LANES-1-i (deskew).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sync_reset_n  input  1  synchronous active-low clear.
- shift  input  1  advance all lanes one step (ignored while draining).
- in_valid  input  1  valid tag loaded with data_i.
- data_i  input  LANES*DATA_WIDTH  packed lane inputs, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- drain_req  input  1  single-cycle request to start drain.
- data_o  output  LANES*DATA_WIDTH  packed lane outputs, lane i = last stage of lane i.
- valid_o  output  LANES  valid bit of last stage of each lane.
- empty_o  output  1  no valid bit set in any stage of any lane.
- busy_o  output  1  drain in progress.
- drain_done_o  output  1  one-cycle pulse when drain completes.

Behaviour:
- Depth: MAX_DEPTH = BASE_DELAY+LANES-1. Lane depth is set by DIRECTION as above.
- Reset (reset_n low, async): all data stages 0, all valid bits 0, FSM IDLE, drain counter 0, drain_done_o 0. Resulting outputs: data_o=0, valid_o=0, empty_o=1, busy_o=0.
- sync_reset_n low: same clear on the clock edge. It has priority over shift, drain_req and an active drain. Asserting it mid-drain returns the FSM to IDLE with no drain_done_o pulse.
- IDLE, shift=1:
  - Every lane's stage0 loads its data_i slice and in_valid.
  - Stage k loads stage k-1.
- IDLE, shift=0: all stages hold.
- data_o/valid_o lane i therefore show the input presented depth(i) shift-edges earlier. Latency counts shift edges, not clocks.
- drain_req in IDLE:
  - Next state is DRAIN and the counter loads MAX_DEPTH.
  - shift is still honoured on that same edge.
  - A drain_req while already empty still runs the full MAX_DEPTH sequence.
- DRAIN:
  - Every clock advances all lanes, inserting data 0 with valid 0. shift, in_valid and data_i are ignored.
  - The counter decrements each cycle.
  - On the edge where the counter goes 1->0, the FSM returns to IDLE and drain_done_o is registered 1 for exactly the following cycle.
  - drain_req during DRAIN is ignored (no restart, no extension).
- busy_o = (state==DRAIN), registered state.
- empty_o: combinational OR-reduce of all valid bits, inverted.
- After any completed drain, all stages are 0 and empty_o=1.
- No width growth or arithmetic on data; data passes bit-exact.
- LANES=1 is legal: single lane of depth BASE_DELAY.

Test Plan:
1. DATA_WIDTH=8, LANES=4, BASE_DELAY=1, DIRECTION=0. One shift with in_valid=1, data_i lanes {0x10,0x20,0x30,0x40}, then shift held 1 with in_valid=0. Required response:
   - lane0 shows 0x10/valid after edge 1.
   - lane1 shows 0x20 after edge 2, lane2 0x30 after edge 3, lane3 0x40 after edge 4.
   - Each valid_o bit is high for exactly one cycle.
2. Same stimulus with DIRECTION=1 -> lane3 emerges after edge 1 and lane0 after edge 4.
3. Load 3 valid words, shift low for 5 cycles -> outputs frozen, empty_o=0. Resume shift -> words continue in order, no loss or duplication.
4. Load 2 valid words, pulse drain_req with shift=0:
   - busy_o high for 4 cycles.
   - Remaining valid words appear on lanes at the correct skew.
   - drain_done_o pulses once in cycle 5; empty_o=1 and data_o=0 afterwards.
   - A second drain_req issued mid-drain has no effect on the timing.
5. During drain cycle 2, drive sync_reset_n low for one clock -> next cycle all stages 0, busy_o=0, no drain_done_o pulse ever appears.
6. Assert reset_n low asynchronously between clock edges with data loaded -> outputs go 0 and empty_o goes 1 immediately without a clock edge. Release -> block idle, accepts shift on the next edge.
